// File: rtl/gpu_cmd_pkg.sv
// Shared types and constants for the GPU command streamer.
package gpu_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int unsigned CMD_DATA_W = 32;
  // ROM bit that routes a word to GP1 instead of GP0
  localparam int unsigned GP_SEL_BIT = CMD_DATA_W;

  typedef struct packed {
    logic                  sel;
    logic [CMD_DATA_W-1:0] data;
  } cmd_word_t;

endpackage

// File: rtl/gpu_cmd_streamer_fifo.sv
// Small synchronous skid FIFO holding ROM words until the GPU FIFO accepts them.
module cmd_skid_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         head_valid,
  output logic [WIDTH-1:0]             head_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop, full;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full       = (cnt_q == OCC_W'(DEPTH));
  assign do_pop     = pop & (cnt_q != '0);
  assign do_push    = push & (~full | do_pop);
  assign occupancy  = cnt_q;
  assign head_valid = (cnt_q != '0);
  assign head_data  = mem_q[rd_q];

  // Next pointer / storage state; flush wins over push and pop.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = inc_ptr(wr_q);
      end
      if (do_pop) begin
        rd_d = inc_ptr(rd_q);
      end
      cnt_d = cnt_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

  // Register FIFO state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpu_cmd_streamer.sv
// Streams a block of command words from a sync-read ROM to GPU GP0/GP1.
module gpu_cmd_streamer
  import gpu_cmd_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              loop_en,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W:0]   rom_q,
  output logic [DATA_W-1:0] main_bus,
  output logic              to_gp0,
  output logic              to_gp1,
  input  logic              fifo_full,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              loop_q, loop_d;
  logic              inflight_q, inflight_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [OCC_W-1:0]  occupancy;
  logic              head_valid;
  logic [DATA_W:0]   head_data;
  logic              head_sel;
  logic              abort_act, strobe, issue;
  logic [OCC_W:0]    level;

  cmd_skid_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_q & ~abort_act),
    .push_data  (rom_q),
    .pop        (strobe),
    .flush      (abort_act),
    .occupancy  (occupancy),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign head_sel   = head_data[DATA_W];
  assign abort_act  = abort & (state_q != IDLE);
  assign strobe     = head_valid & ~fifo_full & ~abort_act;
  assign to_gp0     = strobe & ~head_sel;
  assign to_gp1     = strobe & head_sel;
  assign main_bus   = head_valid ? head_data[DATA_W-1:0] : '0;
  assign rom_addr   = rom_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign words_sent = words_q;

  // Buffer level after this cycle's pop, counting the read still in flight.
  assign level = {1'b0, occupancy} + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(strobe);
  assign issue = (state_q == STREAM) & ~abort_act & (remaining_q != '0) &
                 (level < (OCC_W+1)'(BUF_DEPTH));

  // Sequencer next-state: start latching, read issue, drain, abort.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    base_d      = base_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    loop_d      = loop_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    inflight_d  = issue;
    words_d     = words_q + CNT_W'(strobe);

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          base_d      = base_addr;
          count_d     = word_count;
          loop_d      = loop_en;
          rom_addr_d  = base_addr;
          remaining_d = word_count;
          words_d     = '0;
          if (word_count == '0) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = STREAM;
            busy_d  = 1'b1;
          end
        end
      end
      STREAM: begin
        if (issue) begin
          if (remaining_q == CNT_W'(1)) begin
            if (loop_q) begin
              rom_addr_d  = base_q;
              remaining_d = count_q;
            end else begin
              rom_addr_d  = rom_addr_q + ADDR_W'(1);
              remaining_d = '0;
              state_d     = DRAIN;
            end
          end else begin
            rom_addr_d  = rom_addr_q + ADDR_W'(1);
            remaining_d = remaining_q - CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        // Leave as soon as the buffer will be empty after this cycle's pop,
        // so done lands the cycle right after the final strobe.
        if (!inflight_q &&
            ((occupancy == '0) || ((occupancy == OCC_W'(1)) && strobe))) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort_act) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      inflight_d = 1'b0;
    end
  end

  // Register sequencer state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      base_q      <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      loop_q      <= 1'b0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      base_q      <= base_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      loop_q      <= loop_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      words_q     <= words_d;
    end
  end

endmodule

// File: tb/tb_gpu_cmd_streamer.sv
// Scoreboard bench for gpu_cmd_streamer with a behavioural ROM model.
module tb_gpu_cmd_streamer;
  import gpu_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [19:0] word_count = '0;
  logic        loop_en = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  rom_addr;
  logic [32:0] rom_q = '0;
  logic [31:0] main_bus;
  logic        to_gp0, to_gp1;
  logic        fifo_full = 1'b0;
  logic        busy, done;
  logic [19:0] words_sent;

  gpu_cmd_streamer #(.DATA_W(32), .ADDR_W(10), .CNT_W(20), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .loop_en(loop_en), .abort(abort),
    .rom_addr(rom_addr), .rom_q(rom_q), .main_bus(main_bus),
    .to_gp0(to_gp0), .to_gp1(to_gp1), .fifo_full(fifo_full),
    .busy(busy), .done(done), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  logic [32:0] rom_mem [1024];
  cmd_word_t   exp_q [$];
  int          strobe_rel [$];
  logic [9:0]  addr_log [8];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0;
  int nstrobes = 0, ndone = 0, done_rel = -1;
  int full_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous-read ROM
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // fifo_full driver
  initial forever begin
    int rel;
    @(posedge clk);
    #1;
    rel = cyc - start_cyc;
    case (full_mode)
      1: fifo_full = 1'($urandom_range(0, 1));
      2: begin
        if (rel >= 4 && rel <= 9) fifo_full = 1'b1;
        else if (rel > 9)         fifo_full = ((rel % 2) == 0);
        else                      fifo_full = 1'b0;
      end
      default: fifo_full = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every strobe
  initial forever begin
    int rel;
    cmd_word_t e;
    @(negedge clk);
    rel = cyc - start_cyc;
    if (rel >= 0 && rel < 8) addr_log[rel] = rom_addr;
    if (to_gp0 || to_gp1) begin
      nstrobes++;
      strobe_rel.push_back(rel);
      chk("strobe_while_full", 64'(fifo_full), 64'd0);
      chk("both_strobes", 64'(to_gp0 & to_gp1), 64'd0);
      if (exp_q.size() == 0) chk("unexpected_strobe", 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        chk("word", 64'({to_gp1, main_bus}), 64'(e));
      end
    end
    if (done) begin
      ndone++;
      done_rel = rel;
    end
  end

  task automatic start_xfer(input logic [9:0] b, input logic [19:0] c, input logic lp);
    int n;
    n = lp ? 30 : int'(c);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(cmd_word_t'(rom_mem[(int'(b) + (i % (int'(c) == 0 ? 1 : int'(c)))) % 1024]));
    end
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = b; word_count = c; loop_en = lp;
    start_cyc = cyc; nstrobes = 0; ndone = 0; done_rel = -1;
    strobe_rel.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic [19:0] c);
    int got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk("done_seen", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    chk("words_sent", 64'(words_sent), 64'(c));
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("done_pulses", 64'(ndone), 64'd1);
  endtask

  initial begin
    int n_before, got;
    logic [9:0] b;
    logic [19:0] c;
    for (int i = 0; i < 1024; i++) rom_mem[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
    b = 10'h010;
    for (int i = 0; i < 4; i++) rom_mem[int'(b) + i][GP_SEL_BIT] = (i == 1);

    // Reset values
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_words", 64'(words_sent), 64'd0);
    chk("rst_strobes", 64'({to_gp0, to_gp1}), 64'd0);
    chk("rst_main_bus", 64'(main_bus), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic stream
    start_xfer(10'h010, 20'd4, 1'b0);
    wait_done(40, 20'd4);
    chk("basic_nstrobes", 64'(strobe_rel.size()), 64'd4);
    for (int i = 0; i < 4 && i < strobe_rel.size(); i++)
      chk("basic_strobe_cycle", 64'(strobe_rel[i]), 64'(3 + i));
    chk("basic_done_cycle", 64'(done_rel), 64'd7);

    // Backpressure
    full_mode = 2;
    start_xfer(10'($urandom), 20'd8, 1'b0);
    wait_done(100, 20'd8);
    chk("bp_nstrobes", 64'(nstrobes), 64'd8);
    full_mode = 0;

    // Address wrap
    start_xfer(10'h3FE, 20'd4, 1'b0);
    wait_done(40, 20'd4);
    for (int i = 0; i < 4; i++)
      chk("wrap_rom_addr", 64'(addr_log[i + 1]), 64'((10'h3FE + i) % 1024));

    // Loop plus abort
    start_xfer(10'd0, 20'd3, 1'b1);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (nstrobes >= 10) begin got = 1; break; end
    end
    chk("loop_reached_10", 64'(got), 64'd1);
    abort = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("busy_after_abort", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    chk("abort_nstrobes", 64'(nstrobes), 64'd10);
    chk("loop_no_done", 64'(ndone), 64'd0);

    // Zero count
    start_xfer(10'($urandom), 20'd0, 1'b0);
    repeat (5) @(negedge clk);
    chk("zero_done_cycle", 64'(done_rel), 64'd1);
    chk("zero_done_pulses", 64'(ndone), 64'd1);
    chk("zero_nstrobes", 64'(nstrobes), 64'd0);
    chk("zero_words", 64'(words_sent), 64'd0);

    // Start while busy is ignored
    start_xfer(10'h100, 20'd6, 1'b0);
    @(posedge clk);
    #1 start = 1'b1; base_addr = 10'h200; word_count = 20'd13;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(60, 20'd6);

    // Randomised transfers under random backpressure
    full_mode = 1;
    for (int t = 0; t < 6; t++) begin
      c = 20'($urandom_range(1, 40));
      start_xfer(10'($urandom), c, 1'b0);
      wait_done(400, c);
      chk("rand_nstrobes", 64'(nstrobes), 64'(c));
    end
    full_mode = 0;

    // Reset mid-transfer
    start_xfer(10'($urandom), 20'd20, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_words", 64'(words_sent), 64'd0);
    chk("mid_rst_strobes", 64'({to_gp0, to_gp1}), 64'd0);
    chk("mid_rst_main_bus", 64'(main_bus), 64'd0);
    exp_q.delete();
    n_before = nstrobes;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_nstrobes", 64'(nstrobes), 64'(n_before));
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
